lights_scheduler: RTL and testbench

- Sequences the `lights` FSM on the DE1_SoC board from the full-rate 50 MHz clock, with no gated or divided clocks.
- Generates a one-cycle step enable at a switch-selectable rate and synchronizes the pattern and pause switches.
- Defers pattern (mode) changes to a step boundary; on each change it issues a one-cycle clear so the lights FSM restarts cleanly in the new pattern.
- Sits between SW/KEY and `lights`; its outputs replace the divided clock that drives `lights`.

---
 rtl/lights_pkg.sv | 36 +++
 rtl/lights_scheduler_sync2.sv | 39 +++
 rtl/lights_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_lights_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/lights_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lights_pkg
// Description : Shared types and constants for the lights scheduler. Contains
//               the scheduler state encoding, the pattern type, the speed-select
//               codes and a helper that derives the step period.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lights_pkg;

    // Scheduler states. The encoding is given an explicit width and explicit
    // values so the state register is stable across tools.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSE  = 2'd1,
        SWITCH = 2'd2
    } sched_state_t;

    // Pattern currently driven into the lights FSM.
    typedef logic [1:0] mode_t;

    // Speed-select codes (SW[3:2]). Each step halves the step period.
    localparam logic [1:0] SPEED_DIV1 = 2'd0;
    localparam logic [1:0] SPEED_DIV2 = 2'd1;
    localparam logic [1:0] SPEED_DIV4 = 2'd2;
    localparam logic [1:0] SPEED_DIV8 = 2'd3;

    // Step period in clk cycles for a given base period and speed code.
    function automatic logic [31:0] step_limit(input int unsigned tick_cycles,
                                               input logic [1:0]   spd);
        return 32'(tick_cycles) >> spd;
    endfunction

endpackage : lights_pkg
`default_nettype wire

// File: rtl/lights_scheduler_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Parameterised-width two-flop synchroniser for slow,
//               asynchronous switch inputs. Each bit is synchronised
//               independently; the inputs are quasi-static switches, so no
//               multi-bit coherency is needed.
// Ports       : clk     - destination clock
//               reset_n - asynchronous active-low reset (outputs clear to 0)
//               d       - asynchronous input bus
//               q       - synchronised output bus
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/lights_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lights_scheduler
// Description : Sequences the lights FSM from the full-rate system clock.
//               Produces a one-cycle step enable at a switch-selectable rate,
//               and applies pattern changes only at step boundaries, issuing a
//               one-cycle clear so the lights FSM restarts in the new pattern.
// Ports       : clk      - system clock (CLOCK_50)
//               reset_n  - asynchronous active-low reset
//               mode_req - requested pattern (SW[1:0]), asynchronous
//               speed    - rate select (SW[3:2]), asynchronous;
//                          step period = TICK_CYCLES >> speed
//               pause    - hold request (SW[4]), asynchronous
//               step     - one-cycle step enable to lights
//               clear    - one-cycle pattern restart to lights
//               mode     - pattern currently applied to lights
//               pending  - synchronised request differs from mode
//               running  - high while in RUN
// Revision    : 1.0 - initial release
// ============================================================================
module lights_scheduler
    import lights_pkg::*;
#(
    parameter int TICK_CYCLES = 25_000_000,  // must be >= 8
    parameter int CNT_W       = $clog2(TICK_CYCLES)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] mode_req,
    input  logic [1:0] speed,
    input  logic       pause,
    output logic       step,
    output logic       clear,
    output logic [1:0] mode,
    output logic       pending,
    output logic       running
);

    // ------------------------------------------------------------------
    // Input synchronisation: all five switch bits share one synchroniser.
    // ------------------------------------------------------------------
    logic [4:0] w_sw_s;
    mode_t      w_mode_req_s;
    logic [1:0] w_speed_s;
    logic       w_pause_s;

    sync2 #(
        .WIDTH (5)
    ) u_sync2 (
        .clk     (clk),
        .reset_n (reset_n),
        .d       ({pause, speed, mode_req}),
        .q       (w_sw_s)
    );

    assign w_mode_req_s = w_sw_s[1:0];
    assign w_speed_s    = w_sw_s[3:2];
    assign w_pause_s    = w_sw_s[4];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    sched_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    mode_t            r_mode;
    logic             r_step;
    logic             r_clear;
    logic             r_pending;
    logic             r_running;

    // ------------------------------------------------------------------
    // Step period. The limit itself may need one bit more than the counter
    // (limit == 2**CNT_W when TICK_CYCLES is a power of two), so compare in
    // 32 bits. Using ">=" rather than "==" makes a speed increase mid-count
    // fire on the next edge instead of running past the new limit.
    // ------------------------------------------------------------------
    logic [31:0] w_limit;
    logic [31:0] w_limit_m1;
    logic        w_at_tick;
    logic        w_mode_diff;

    assign w_limit     = step_limit(TICK_CYCLES, w_speed_s);
    assign w_limit_m1  = w_limit - 32'd1;
    assign w_at_tick   = (32'(r_cnt) >= w_limit_m1);
    assign w_mode_diff = (w_mode_req_s != r_mode);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    sched_state_t w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                // Pause wins over a coincident tick.
                if (w_pause_s) begin
                    w_state_nxt = PAUSE;
                end else if (w_at_tick && w_mode_diff) begin
                    w_state_nxt = SWITCH;
                end
            end
            PAUSE: begin
                if (!w_pause_s) begin
                    w_state_nxt = w_mode_diff ? SWITCH : RUN;
                end
            end
            SWITCH: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic: next values of the registered outputs.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] w_cnt_nxt;
    mode_t            w_mode_nxt;
    logic             w_step_nxt;
    logic             w_clear_nxt;
    logic             w_pending_nxt;
    logic             w_running_nxt;

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_mode_nxt    = r_mode;
        w_step_nxt    = 1'b0;
        w_clear_nxt   = 1'b0;
        w_pending_nxt = w_mode_diff;
        w_running_nxt = (w_state_nxt == RUN);
        case (r_state)
            RUN: begin
                if (!w_pause_s) begin
                    if (w_at_tick) begin
                        w_cnt_nxt = '0;
                        // A tick that starts a pattern switch is swallowed so
                        // the old pattern never advances past the boundary.
                        w_step_nxt = !w_mode_diff;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            SWITCH: begin
                // mode_req_s is re-sampled here; a later change waits for
                // the next tick.
                w_mode_nxt  = w_mode_req_s;
                w_clear_nxt = 1'b1;
                w_cnt_nxt   = '0;
            end
            PAUSE: begin
                // Count held so the step period resumes where it stopped.
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_mode    <= '0;
            r_step    <= 1'b0;
            r_clear   <= 1'b0;
            r_pending <= 1'b0;
            r_running <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_mode    <= w_mode_nxt;
            r_step    <= w_step_nxt;
            r_clear   <= w_clear_nxt;
            r_pending <= w_pending_nxt;
            r_running <= w_running_nxt;
        end
    end

    assign step    = r_step;
    assign clear   = r_clear;
    assign mode    = r_mode;
    assign pending = r_pending;
    assign running = r_running;

endmodule : lights_scheduler
`default_nettype wire

// File: tb/tb_lights_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_lights_scheduler
// Description : Directed self-checking bench for lights_scheduler with
//               TICK_CYCLES = 8. Inputs change and outputs are sampled on the
//               falling clock edge; expected values are hand-derived.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lights_scheduler;

    logic       clk;
    logic       reset_n;
    logic [1:0] mode_req;
    logic [1:0] speed;
    logic       pause;
    logic       step;
    logic       clear;
    logic [1:0] mode;
    logic       pending;
    logic       running;

    int total = 0;
    int bad   = 0;
    int n_clear = 0;
    int n_both  = 0;
    int cyc;
    int steps_seen;

    lights_scheduler #(
        .TICK_CYCLES (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mode_req (mode_req),
        .speed    (speed),
        .pause    (pause),
        .step     (step),
        .clear    (clear),
        .mode     (mode),
        .pending  (pending),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running tallies of clear pulses and step/clear overlap.
    always @(negedge clk) begin
        if (clear === 1'b1) n_clear++;
        if (step === 1'b1 && clear === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Count falling edges until step is seen; -1 on timeout.
    task automatic wait_step(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (step !== 1'b1 && n < max);
        if (step !== 1'b1) n = -1;
    endtask

    initial begin
        reset_n  = 1'b0;
        mode_req = 2'd0;
        speed    = 2'd0;
        pause    = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- reset state ----------------
        chk("rst_step",    32'(step),    32'd0);
        chk("rst_clear",   32'(clear),   32'd0);
        chk("rst_mode",    32'(mode),    32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_running", 32'(running), 32'd1);

        // ---------------- speed 0: period 8 ----------------
        reset_n = 1'b1;
        wait_step(40, cyc); chk("s0_first_step", 32'(cyc), 32'd8);
        wait_step(40, cyc); chk("s0_period",     32'(cyc), 32'd8);
        chk("s0_mode", 32'(mode), 32'd0);

        // ---------------- speed 2: period 2 ----------------
        speed = 2'd2;
        wait_step(40, cyc); chk("s2_first", 32'(cyc), 32'd3);
        wait_step(40, cyc); chk("s2_per_a", 32'(cyc), 32'd2);
        wait_step(40, cyc); chk("s2_per_b", 32'(cyc), 32'd2);

        // back to speed 0 (one more period-2 tick before it takes effect)
        speed = 2'd0;
        wait_step(40, cyc); chk("s2to0_last", 32'(cyc), 32'd2);
        wait_step(40, cyc); chk("s0_again",   32'(cyc), 32'd8);

        // ---------------- speed 0 -> 3 with cnt = 5 ----------------
        repeat (3) @(negedge clk);   // cnt = 3; cnt = 5 when speed_s lands
        speed = 2'd3;
        wait_step(40, cyc); chk("s3_next_edge", 32'(cyc), 32'd3);
        wait_step(40, cyc); chk("s3_per_a",     32'(cyc), 32'd1);
        wait_step(40, cyc); chk("s3_per_b",     32'(cyc), 32'd1);
        speed = 2'd0;
        repeat (2) @(negedge clk);   // two more period-1 ticks in the pipe
        wait_step(40, cyc); chk("s3to0_period", 32'(cyc), 32'd8);
        chk("no_clear_yet", 32'(n_clear), 32'd0);

        // ---------------- mode change 0 -> 2 mid-count ----------------
        repeat (2) @(negedge clk);   // cnt = 2
        mode_req = 2'd2;
        @(negedge clk); chk("mc_pend_a1", 32'(pending), 32'd0);
        @(negedge clk); chk("mc_pend_a2", 32'(pending), 32'd0);
        @(negedge clk); chk("mc_pend_a3", 32'(pending), 32'd1);
        @(negedge clk); chk("mc_step_a4", 32'(step), 32'd0);
        @(negedge clk); chk("mc_step_a5", 32'(step), 32'd0);
        @(negedge clk);              // SWITCH cycle: tick swallowed
        chk("mc_sw_step",    32'(step),    32'd0);
        chk("mc_sw_running", 32'(running), 32'd0);
        chk("mc_sw_clear",   32'(clear),   32'd0);
        chk("mc_sw_mode",    32'(mode),    32'd0);
        @(negedge clk);
        chk("mc_clear", 32'(clear), 32'd1);
        chk("mc_mode",  32'(mode),  32'd2);
        chk("mc_step",  32'(step),  32'd0);
        wait_step(40, cyc); chk("mc_first_step", 32'(cyc), 32'd8);
        chk("mc_pending_off", 32'(pending), 32'd0);

        // ---------------- pause at cnt = 3 ----------------
        @(negedge clk);              // cnt = 1
        pause = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("pz_run_b2", 32'(running), 32'd1);
        @(negedge clk); chk("pz_run_b3", 32'(running), 32'd0);
        steps_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (step === 1'b1) steps_seen++;
        end
        chk("pz_no_step", 32'(steps_seen), 32'd0);
        pause = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("pz_rel_c2", 32'(running), 32'd0);
        @(negedge clk); chk("pz_rel_c3", 32'(running), 32'd1);
        wait_step(40, cyc); chk("pz_resume_step", 32'(cyc), 32'd5);

        // ---------------- mode change while paused ----------------
        pause = 1'b1;
        repeat (3) @(negedge clk);
        mode_req = 2'd1;
        repeat (4) @(negedge clk);
        mode_req = 2'd3;
        repeat (4) @(negedge clk);
        chk("pm_pending", 32'(pending), 32'd1);
        chk("pm_mode",    32'(mode),    32'd2);
        chk("pm_running", 32'(running), 32'd0);
        pause = 1'b0;
        steps_seen = 0;
        @(negedge clk); if (step === 1'b1) steps_seen++;
        @(negedge clk); if (step === 1'b1) steps_seen++;
        @(negedge clk); if (step === 1'b1) steps_seen++;
        chk("pm_sw_running", 32'(running), 32'd0);
        @(negedge clk); if (step === 1'b1) steps_seen++;
        chk("pm_clear",   32'(clear),      32'd1);
        chk("pm_mode3",   32'(mode),       32'd3);
        chk("pm_no_step", 32'(steps_seen), 32'd0);
        wait_step(40, cyc); chk("pm_first_step", 32'(cyc), 32'd8);

        // ---------------- reset during SWITCH ----------------
        mode_req = 2'd1;
        repeat (8) @(negedge clk);   // tick edge -> SWITCH
        chk("rs_sw_running", 32'(running), 32'd0);
        chk("rs_sw_pending", 32'(pending), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rs_step",    32'(step),    32'd0);
        chk("rs_clear",   32'(clear),   32'd0);
        chk("rs_mode",    32'(mode),    32'd0);
        chk("rs_pending", 32'(pending), 32'd0);
        chk("rs_running", 32'(running), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk); chk("rs_pend_f1", 32'(pending), 32'd0);
        @(negedge clk);
        @(negedge clk); chk("rs_pend_f3", 32'(pending), 32'd1);
        chk("rs_mode_f3", 32'(mode), 32'd0);
        repeat (5) @(negedge clk);
        chk("rs_f8_step", 32'(step), 32'd0);
        @(negedge clk);
        chk("rs_clear_f9", 32'(clear), 32'd1);
        chk("rs_mode_f9",  32'(mode),  32'd1);
        @(negedge clk);

        // ---------------- global invariants ----------------
        chk("clear_pulses",   32'(n_clear), 32'd3);
        chk("step_clear_both", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lights_scheduler
`default_nettype wire
